io_responder: RTL and testbench
===============================

# io_responder

Bus-side responder for the multi-cycle CPU's IO port. It decodes every `io_mode`/`io_addr` request and serves it from three regions: a word-organised RAM, a memory-mapped 8N1 UART (TX FIFO plus RX holding register), and a free-running cycle counter. Reads are answered combinationally in the request cycle. Writes commit at the clock edge ending the request cycle.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words, power of two; RAM base is 0x8000_0000.
- `CLK_DIV`, 16: clock cycles per UART bit, even, ≥4.
- `TX_DEPTH`, 8: TX FIFO entries, power of two.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `io_mode` in 4: request type; 0 idle, 1 read word, 2 write word, 3 read byte, 4 write byte, others idle.
- `io_addr` in 32: byte address.
- `io_wdata` in 32: write data; byte writes use bits [7:0].
- `io_rdata` out 32: read data, combinational.
- `uart_txd` out 1: serial out, idle high.
- `uart_rxd` in 1: serial in, asynchronous to `clk`.
- `err` out 1: sticky bus-error flag.

## Operation
- **Address map:**
  - RAM: 0x8000_0000 to 0x8000_0000 + 4·RAM_WORDS − 1.
  - UART DATA: 0xBFD0_03F8.
  - UART STATUS: 0xBFD0_03FC.
  - CYCLES: 0xBFD0_0400.
  - Anything else is unmapped.
- **RAM:**
  - Word index is addr[log2(RAM_WORDS)+1:2].
  - Word access with addr[1:0] ≠ 0 is a misaligned error.
  - Byte read returns lane addr[1:0], little-endian, zero-extended.
  - Byte write updates only that lane.
  - Contents are not reset.
- **DATA:**
  - Word or byte write pushes `io_wdata[7:0]` to the TX FIFO.
  - A push while the FIFO is full is dropped, including when a pop happens in the same cycle.
  - Read returns {24'b0, rx_byte}. At the ending edge it clears rx_valid and overrun.
- **STATUS (read-only):**
  - bit0: TX FIFO not full.
  - bit1: rx_valid.
  - bit2: overrun.
  - bit3: TX idle (FIFO empty and shifter idle).
  - Other bits read 0; writes are ignored.
- **CYCLES:** 32-bit counter, +1 every cycle, wraps at 2^32. Writes are ignored.
- **Errors:**
  - Any non-idle access that is unmapped or misaligned sets `err` until reset.
  - Such a read returns 0; such a write has no effect.
  - Byte accesses to UART/CYCLES use the aligned word.
- `io_rdata` is 0 whenever `io_mode` is not a read.
- **TX FSM:** states IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop, load shifter, go to START.
  - START holds txd=0 for CLK_DIV cycles.
  - DATA sends 8 bits LSB first, CLK_DIV cycles each.
  - STOP holds txd=1 for CLK_DIV cycles, then returns to IDLE.
- **RX FSM:** states IDLE, START, DATA, STOP. `uart_rxd` passes through a 2-flop synchroniser.
  - IDLE: a synchronised low enters START.
  - START: sample at CLK_DIV/2. If high, treat as a glitch and return to IDLE.
  - DATA: sample each bit CLK_DIV later, LSB first.
  - STOP: sample. If high, load rx_byte and set rx_valid; if rx_valid was already 1, also set overrun (new byte overwrites). If low, discard the frame.
  - Return to IDLE after the STOP sample.
- A DATA read at the same edge a new byte is loaded:
  - the read returns the old byte;
  - rx_valid ends at 1;
  - overrun is cleared.

## Timing
- **Reset (rst_n low, asynchronous):**
  - `uart_txd`=1, `err`=0.
  - FIFO empty; TX and RX in IDLE.
  - rx_valid=0, overrun=0, rx_byte=0, CYCLES=0.
  - `io_rdata` follows the combinational rule.
  - Reset asserted mid-frame aborts TX immediately (txd=1) and discards RX state.
- Read latency 0: `io_rdata` is valid in the same cycle as `io_addr`/`io_mode`.
- Write latency 1: the effect is visible to a read in the following cycle.
- A CYCLES read returns the pre-edge value.
- **TX:**
  - Push at edge E0 into an empty FIFO with TX idle: pop at E1, txd falls after E1.
  - Frame is 10·CLK_DIV cycles.
  - Consecutive frames are separated by exactly one idle-high cycle.
- **RX:** rx_valid rises no more than 10·CLK_DIV + 3 cycles after the start-bit falling edge on `uart_rxd`.
- **FIFO:** read/write pointers carry one extra wrap bit. Full means pointers equal except the wrap bit. Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.

## Test plan
- Write word 0xDEADBEEF to 0x8000_0010, then read word → 0xDEADBEEF. Write byte 0x55 to 0x8000_0012, then read word → 0xDE55BEEF. Read byte at 0x8000_0013 → 0x000000DE.
- With CLK_DIV=4, write 0x41 to DATA → txd low 4 cycles, bits 1,0,0,0,0,0,1,0 at 4 cycles each, high 4 cycles. STATUS bit3 = 1 afterwards.
- Push 9 bytes back-to-back with TX_DEPTH=8 while TX is busy:
  - STATUS bit0 = 0 once 8 are queued;
  - the 9th is dropped;
  - exactly 8 frames follow (or 9 if a pop freed a slot first; checked against the model).
- Drive frame 0xA5 on `uart_rxd` → STATUS bit1 = 1, DATA read → 0xA5, STATUS then 0. Two frames without a read → bit2 = 1 and DATA = second byte.
- Read word 0x0000_0000 and write word 0x8000_0001 → `err`=1, RAM unchanged, read data 0. Assert rst_n low → `err`=0.
- Assert rst_n mid-TX frame → txd=1 immediately, FIFO empty. After release, CYCLES reads 0, 1, 2 on successive cycles.

Source files
------------

// File: rtl/io_responder.sv
// io_responder: bus-side responder for the CPU IO port.
// Serves a word-organised RAM, a memory-mapped 8N1 UART (TX FIFO plus RX
// holding register) and a free-running cycle counter. Reads answer
// combinationally in the request cycle; writes commit at the ending edge.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   io_mode              0 idle, 1 rd word, 2 wr word, 3 rd byte, 4 wr byte
//   io_addr, io_wdata    byte address, write data (byte writes use [7:0])
//   io_rdata             combinational read data, 0 unless a good read
//   uart_txd, uart_rxd   serial out (idle high), serial in (asynchronous)
//   err                  sticky bus-error flag
module io_responder #(
   parameter int unsigned RAM_WORDS = 1024,
   parameter int unsigned CLK_DIV   = 16,
   parameter int unsigned TX_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  io_mode,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic        uart_txd,
   input  logic        uart_rxd,
   output logic        err
);
   localparam int unsigned AW   = $clog2(RAM_WORDS);
   localparam int unsigned PW   = $clog2(TX_DEPTH);
   localparam int unsigned PTRW = PW + 1;
   localparam int unsigned CW   = $clog2(CLK_DIV);
   localparam logic [31:0] RAM_BASE  = 32'h8000_0000;
   localparam logic [31:0] DATA_ADDR = 32'hBFD0_03F8;
   localparam logic [31:0] STAT_ADDR = 32'hBFD0_03FC;
   localparam logic [31:0] CYC_ADDR  = 32'hBFD0_0400;
   localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   // Request decode
   logic is_rd, is_wr, is_byte, misalign;
   logic ram_hit, data_hit, stat_hit, cyc_hit, bad, rd_ok, wr_ok;
   logic [AW-1:0] widx;

   assign is_rd    = (io_mode == 4'd1) || (io_mode == 4'd3);
   assign is_wr    = (io_mode == 4'd2) || (io_mode == 4'd4);
   assign is_byte  = (io_mode == 4'd3) || (io_mode == 4'd4);
   assign misalign = !is_byte && (io_addr[1:0] != 2'b00);
   assign ram_hit  = io_addr[31:AW+2] == RAM_BASE[31:AW+2];
   assign data_hit = io_addr[31:2] == DATA_ADDR[31:2];
   assign stat_hit = io_addr[31:2] == STAT_ADDR[31:2];
   assign cyc_hit  = io_addr[31:2] == CYC_ADDR[31:2];
   assign bad      = (is_rd || is_wr) &&
                     (misalign || !(ram_hit || data_hit || stat_hit || cyc_hit));
   assign rd_ok    = is_rd && !bad;
   assign wr_ok    = is_wr && !bad;
   assign widx     = io_addr[AW+1:2];

   // Storage
   logic [31:0] mem  [RAM_WORDS];
   logic [7:0]  fifo [TX_DEPTH];
   logic [PTRW-1:0] wptr, rptr;
   logic tx_full, tx_empty, push;

   assign tx_full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
   assign tx_empty = (wptr == rptr);
   // A push into a full FIFO is dropped even if a pop frees a slot this cycle
   assign push     = wr_ok && data_hit && !tx_full;

   // RAM and FIFO arrays hold no reset state
   always_ff @(posedge clk) begin
      if (wr_ok && ram_hit) begin
         if (is_byte) mem[widx][{io_addr[1:0], 3'b000} +: 8] <= io_wdata[7:0];
         else         mem[widx] <= io_wdata;
      end
      if (push) fifo[wptr[PW-1:0]] <= io_wdata[7:0];
   end

   // TX FSM and FIFO pointers
   uart_state_t   tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          tx_idle;

   assign tx_idle = tx_empty && (tx_state == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_txd <= 1'b1;
      end else begin
         if (push) wptr <= wptr + PTRW'(1);
         case (tx_state)
            S_IDLE: if (!tx_empty) begin
               tx_shift <= fifo[rptr[PW-1:0]];
               rptr     <= rptr + PTRW'(1);
               tx_cnt   <= '0;
               tx_state <= S_START;
               uart_txd <= 1'b0;
            end
            S_START: if (tx_cnt == BIT_END) begin
               tx_cnt   <= '0;
               tx_bit   <= '0;
               tx_state <= S_DATA;
               uart_txd <= tx_shift[0];
            end else tx_cnt <= tx_cnt + CW'(1);
            S_DATA: if (tx_cnt == BIT_END) begin
               tx_cnt <= '0;
               if (tx_bit == 3'd7) begin
                  tx_state <= S_STOP;
                  uart_txd <= 1'b1;
               end else begin
                  tx_bit   <= tx_bit + 3'd1;
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  uart_txd <= tx_shift[1];
               end
            end else tx_cnt <= tx_cnt + CW'(1);
            S_STOP: if (tx_cnt == BIT_END) begin
               tx_cnt   <= '0;
               tx_state <= S_IDLE;
            end else tx_cnt <= tx_cnt + CW'(1);
            default: tx_state <= S_IDLE;
         endcase
      end
   end

   // RX synchroniser, FSM and holding register
   logic [1:0]    rx_sync;
   uart_state_t   rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift, rx_byte;
   logic          rx_valid, overrun, rxs, rx_load_c, data_rd_c;

   assign rxs       = rx_sync[1];
   assign rx_load_c = (rx_state == S_STOP) && (rx_cnt == BIT_END) && rxs;
   assign data_rd_c = rd_ok && data_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync  <= 2'b11;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], uart_rxd};
         case (rx_state)
            S_IDLE: if (!rxs) begin
               rx_cnt   <= '0;
               rx_state <= S_START;
            end
            // Mid-start-bit check rejects glitches shorter than half a bit
            S_START: if (rx_cnt == HALF_END) begin
               rx_cnt   <= '0;
               rx_bit   <= '0;
               rx_state <= rxs ? S_IDLE : S_DATA;
            end else rx_cnt <= rx_cnt + CW'(1);
            S_DATA: if (rx_cnt == BIT_END) begin
               rx_cnt   <= '0;
               rx_shift <= {rxs, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state <= S_STOP;
               else                rx_bit   <= rx_bit + 3'd1;
            end else rx_cnt <= rx_cnt + CW'(1);
            S_STOP: if (rx_cnt == BIT_END) begin
               rx_cnt   <= '0;
               rx_state <= S_IDLE;
            end else rx_cnt <= rx_cnt + CW'(1);
            default: rx_state <= S_IDLE;
         endcase
         // A load wins over a DATA-read clear of rx_valid; the read still clears overrun
         if (rx_load_c) begin
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
         end else if (data_rd_c) begin
            rx_valid <= 1'b0;
         end
         if (data_rd_c)                   overrun <= 1'b0;
         else if (rx_load_c && rx_valid)  overrun <= 1'b1;
      end
   end

   // Cycle counter and sticky error flag
   logic [31:0] cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycles <= '0;
         err    <= 1'b0;
      end else begin
         cycles <= cycles + 32'd1;
         if (bad) err <= 1'b1;
      end
   end

   // Combinational read mux; byte reads pick the lane of the aligned word
   logic [31:0] reg_word;

   always_comb begin
      reg_word = '0;
      if (ram_hit)       reg_word = mem[widx];
      else if (data_hit) reg_word = {24'd0, rx_byte};
      else if (stat_hit) reg_word = {28'd0, tx_idle, overrun, rx_valid, !tx_full};
      else if (cyc_hit)  reg_word = cycles;
      io_rdata = '0;
      if (rd_ok) io_rdata = is_byte ? {24'd0, reg_word[{io_addr[1:0], 3'b000} +: 8]} : reg_word;
   end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: randomized self-checking bench for io_responder.
// A byte-array RAM model, queue models of the TX path and a behavioural
// serial decoder/encoder supply every expected value.
module tb_io_responder;
   localparam int unsigned RW = 256;
   localparam int unsigned CD = 4;
   localparam int unsigned TD = 8;
   localparam int unsigned FRAME = 10 * CD;
   localparam logic [31:0] RAM_A  = 32'h8000_0000;
   localparam logic [31:0] DATA_A = 32'hBFD0_03F8;
   localparam logic [31:0] STAT_A = 32'hBFD0_03FC;
   localparam logic [31:0] CYC_A  = 32'hBFD0_0400;
   localparam logic [3:0]  RDW = 4'd1, WRW = 4'd2, RDB = 4'd3, WRB = 4'd4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  io_mode = '0;
   logic [31:0] io_addr = '0;
   logic [31:0] io_wdata = '0;
   logic [31:0] io_rdata;
   logic        uart_txd;
   logic        uart_rxd = 1'b1;
   logic        err;

   int          n_chk = 0;
   int          n_pass = 0;
   int unsigned tcyc = 0;
   logic [7:0]  ram_mdl [RW*4];
   logic [8:0]  cap_q [$];
   int unsigned start_q [$];

   io_responder #(.RAM_WORDS(RW), .CLK_DIV(CD), .TX_DEPTH(TD)) dut (
      .clk(clk), .rst_n(rst_n), .io_mode(io_mode), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .uart_txd(uart_txd),
      .uart_rxd(uart_rxd), .err(err));

   always #5 clk = ~clk;
   always @(posedge clk) tcyc <= tcyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", tcyc);
      $fatal(1, "watchdog");
   end

   // Serial decoder on uart_txd: samples mid-bit, records {stop, byte} and start cycle
   initial begin : tx_mon
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && uart_txd === 1'b0) begin
            start_q.push_back(tcyc);
            repeat (CD + CD/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               b[i] = uart_txd;
               repeat (CD) @(negedge clk);
            end
            cap_q.push_back({uart_txd, b});
         end
      end
   end

   function automatic logic [31:0] mdl_word(input int i);
      return {ram_mdl[4*i+3], ram_mdl[4*i+2], ram_mdl[4*i+1], ram_mdl[4*i]};
   endfunction

   function automatic logic [31:0] stat_val(input logic nf, input logic rv,
                                            input logic ov, input logic ti);
      return {28'd0, ti, ov, rv, nf};
   endfunction

   task automatic bus_wr(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
      io_mode = m; io_addr = a; io_wdata = d;
      @(negedge clk);
      io_mode = '0; io_addr = '0; io_wdata = '0;
   endtask

   task automatic bus_rd(input logic [3:0] m, input logic [31:0] a, output logic [31:0] d);
      io_mode = m; io_addr = a;
      #1 d = io_rdata;
      @(negedge clk);
      io_mode = '0; io_addr = '0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      uart_rxd = 1'b0;
      repeat (CD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (CD) @(negedge clk);
      end
      uart_rxd = stop;
      repeat (CD) @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   task automatic wait_frames(input int n, input string nm);
      int t = 0;
      while (cap_q.size() < n && t < n * (FRAME + 2) + 200) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (cap_q.size() !== n) $display("FAIL %s frame count got=%0d exp=%0d", nm, cap_q.size(), n);
      else n_pass++;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(negedge clk);
      n_chk++; if (uart_txd !== 1'b1) $display("FAIL reset_txd got=%b exp=1", uart_txd); else n_pass++;
      n_chk++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
      rst_n = 1'b1;
      bus_rd(RDW, STAT_A, d);
      n_chk++; if (d !== stat_val(1, 0, 0, 1)) $display("FAIL reset_status got=%h exp=%h", d, stat_val(1, 0, 0, 1)); else n_pass++;
      bus_rd(RDW, DATA_A, d);
      n_chk++; if (d !== 32'd0) $display("FAIL reset_rxbyte got=%h exp=0", d); else n_pass++;
      io_mode = 4'd5; io_addr = STAT_A;
      #1;
      n_chk++; if (io_rdata !== 32'd0) $display("FAIL idle_mode_rdata got=%h exp=0", io_rdata); else n_pass++;
      @(negedge clk);
      io_mode = '0; io_addr = '0;
      n_chk++; if (err !== 1'b0) $display("FAIL idle_mode_err got=%b exp=0", err); else n_pass++;
   endtask

   task automatic test_ram();
      logic [31:0] d, exp;
      int idx, ln;
      for (int i = 0; i < RW; i++) begin
         d = $urandom;
         bus_wr(WRW, RAM_A + 32'(i * 4), d);
         for (int j = 0; j < 4; j++) ram_mdl[4*i+j] = d[8*j +: 8];
      end
      bus_wr(WRW, 32'h8000_0010, 32'hDEAD_BEEF);
      bus_rd(RDW, 32'h8000_0010, d);
      n_chk++; if (d !== 32'hDEAD_BEEF) $display("FAIL ram_word got=%h exp=DEADBEEF", d); else n_pass++;
      bus_wr(WRB, 32'h8000_0012, 32'hFFFF_FF55);
      bus_rd(RDW, 32'h8000_0010, d);
      n_chk++; if (d !== 32'hDE55_BEEF) $display("FAIL ram_bytewr got=%h exp=DE55BEEF", d); else n_pass++;
      bus_rd(RDB, 32'h8000_0013, d);
      n_chk++; if (d !== 32'h0000_00DE) $display("FAIL ram_byterd got=%h exp=000000DE", d); else n_pass++;
      ram_mdl[16] = 8'hEF; ram_mdl[17] = 8'hBE; ram_mdl[18] = 8'h55; ram_mdl[19] = 8'hDE;
      bus_rd(RDW, RAM_A + 32'((RW - 1) * 4), d);
      n_chk++; if (d !== mdl_word(RW - 1)) $display("FAIL ram_top got=%h exp=%h", d, mdl_word(RW - 1)); else n_pass++;
      for (int k = 0; k < 300; k++) begin
         idx = int'($urandom_range(0, RW - 1));
         ln  = int'($urandom_range(0, 3));
         d   = $urandom;
         case ($urandom_range(0, 3))
            0: begin
               bus_wr(WRW, RAM_A + 32'(idx * 4), d);
               for (int j = 0; j < 4; j++) ram_mdl[4*idx+j] = d[8*j +: 8];
            end
            1: begin
               bus_wr(WRB, RAM_A + 32'(idx * 4 + ln), d);
               ram_mdl[4*idx+ln] = d[7:0];
            end
            2: begin
               exp = mdl_word(idx);
               bus_rd(RDW, RAM_A + 32'(idx * 4), d);
               n_chk++; if (d !== exp) $display("FAIL ram_rand_word idx=%0d got=%h exp=%h", idx, d, exp); else n_pass++;
            end
            default: begin
               exp = {24'd0, ram_mdl[4*idx+ln]};
               bus_rd(RDB, RAM_A + 32'(idx * 4 + ln), d);
               n_chk++; if (d !== exp) $display("FAIL ram_rand_byte a=%0d got=%h exp=%h", 4*idx+ln, d, exp); else n_pass++;
            end
         endcase
      end
      n_chk++; if (err !== 1'b0) $display("FAIL ram_err got=%b exp=0", err); else n_pass++;
   endtask

   task automatic test_cycles();
      logic [31:0] c0, c1, exp;
      int k;
      for (int r = 0; r < 3; r++) begin
         k = int'($urandom_range(1, 20));
         bus_rd(RDW, CYC_A, c0);
         repeat (k) @(negedge clk);
         bus_wr(WRW, CYC_A, $urandom);
         bus_rd(RDW, CYC_A, c1);
         exp = c0 + 32'(k + 2);
         n_chk++; if (c1 !== exp) $display("FAIL cycles_delta got=%h exp=%h", c1, exp); else n_pass++;
      end
   endtask

   task automatic test_tx_frame();
      logic [31:0] d;
      logic [7:0]  b = 8'h41;
      logic        e;
      logic [8:0]  f;
      bus_wr(WRW, DATA_A, 32'hABCD_EF41);
      n_chk++; if (uart_txd !== 1'b1) $display("FAIL tx_before_pop got=%b exp=1", uart_txd); else n_pass++;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i < 4)       e = 1'b0;
         else if (i < 36) e = b[(i - 4) / 4];
         else             e = 1'b1;
         n_chk++; if (uart_txd !== e) $display("FAIL tx_wave i=%0d got=%b exp=%b", i, uart_txd, e); else n_pass++;
      end
      @(negedge clk);
      bus_rd(RDW, STAT_A, d);
      n_chk++; if (d !== stat_val(1, 0, 0, 1)) $display("FAIL tx_done_status got=%h exp=%h", d, stat_val(1, 0, 0, 1)); else n_pass++;
      wait_frames(1, "tx_frame");
      f = (cap_q.size() > 0) ? cap_q.pop_front() : 9'h0;
      n_chk++; if (f !== 9'h141) $display("FAIL tx_frame_byte got=%h exp=141", f); else n_pass++;
      cap_q.delete(); start_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [7:0]  exp_q [$];
      logic [7:0]  fifo_mdl [$];
      logic [7:0]  b;
      logic [8:0]  f;
      b = 8'($urandom);
      bus_wr(WRW, DATA_A, {24'd0, b});
      exp_q.push_back(b);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         b = 8'($urandom);
         bus_wr(WRB, DATA_A, {$urandom_range(0, 255), b});
         if (fifo_mdl.size() < TD) begin
            fifo_mdl.push_back(b);
            exp_q.push_back(b);
         end
      end
      bus_rd(RDW, STAT_A, d);
      n_chk++; if (d[0] !== (fifo_mdl.size() < TD)) $display("FAIL fifo_full_flag got=%b exp=%b", d[0], fifo_mdl.size() < TD); else n_pass++;
      n_chk++; if (d[3] !== 1'b0) $display("FAIL fifo_busy_idle got=%b exp=0", d[3]); else n_pass++;
      wait_frames(exp_q.size(), "b2b");
      repeat (FRAME + 10) @(negedge clk);
      n_chk++; if (cap_q.size() !== exp_q.size()) $display("FAIL b2b_extra got=%0d exp=%0d", cap_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         f = cap_q[i];
         n_chk++; if (f !== {1'b1, exp_q[i]}) $display("FAIL b2b_byte i=%0d got=%h exp=%h", i, f, {1'b1, exp_q[i]}); else n_pass++;
      end
      for (int i = 1; i < start_q.size(); i++) begin
         n_chk++;
         if (start_q[i] - start_q[i-1] !== FRAME + 1)
            $display("FAIL b2b_gap i=%0d got=%0d exp=%0d", i, start_q[i] - start_q[i-1], FRAME + 1);
         else n_pass++;
      end
      cap_q.delete(); start_q.delete();
   endtask

   task automatic test_tx_random();
      logic [7:0] exp_q [$];
      logic [7:0] b;
      logic [8:0] f;
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 1) == 1) bus_wr(WRW, DATA_A, {$urandom_range(0, 32'hFFFFFF), b});
         else bus_wr(WRB, DATA_A + 32'($urandom_range(0, 3)), {24'd0, b});
         exp_q.push_back(b);
         repeat ($urandom_range(0, 60)) @(negedge clk);
      end
      wait_frames(exp_q.size(), "tx_rand");
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         f = cap_q[i];
         n_chk++; if (f !== {1'b1, exp_q[i]}) $display("FAIL tx_rand_byte i=%0d got=%h exp=%h", i, f, {1'b1, exp_q[i]}); else n_pass++;
      end
      cap_q.delete(); start_q.delete();
   endtask

   task automatic rx_expect(input logic [7:0] b, input string nm);
      logic [31:0] d;
      logic        v = 1'b0;
      for (int p = 0; p < 4 && !v; p++) begin
         bus_rd(RDW, STAT_A, d);
         v = d[1];
      end
      n_chk++; if (v !== 1'b1) $display("FAIL %s rx_valid_timeout got=%b exp=1", nm, v); else n_pass++;
      bus_rd(RDW, DATA_A, d);
      n_chk++; if (d !== {24'd0, b}) $display("FAIL %s rx_data got=%h exp=%h", nm, d, {24'd0, b}); else n_pass++;
      bus_rd(RDW, STAT_A, d);
      n_chk++; if (d !== stat_val(1, 0, 0, 1)) $display("FAIL %s rx_cleared got=%h exp=%h", nm, d, stat_val(1, 0, 0, 1)); else n_pass++;
   endtask

   task automatic test_rx();
      logic [31:0] d;
      logic [7:0]  a, b;
      send_rx(8'hA5, 1'b1);
      rx_expect(8'hA5, "rx_a5");
      for (int i = 0; i < 3; i++) begin
         a = 8'($urandom);
         send_rx(a, 1'b1);
         rx_expect(a, "rx_rand");
      end
      a = 8'($urandom);
      b = 8'($urandom);
      send_rx(a, 1'b1);
      send_rx(b, 1'b1);
      repeat (4) @(negedge clk);
      bus_rd(RDW, STAT_A, d);
      n_chk++; if (d !== stat_val(1, 1, 1, 1)) $display("FAIL rx_overrun_status got=%h exp=%h", d, stat_val(1, 1, 1, 1)); else n_pass++;
      bus_rd(RDW, DATA_A, d);
      n_chk++; if (d !== {24'd0, b}) $display("FAIL rx_overrun_data got=%h exp=%h", d, {24'd0, b}); else n_pass++;
      bus_rd(RDW, STAT_A, d);
      n_chk++; if (d !== stat_val(1, 0, 0, 1)) $display("FAIL rx_overrun_clear got=%h exp=%h", d, stat_val(1, 0, 0, 1)); else n_pass++;
      uart_rxd = 1'b0;
      @(negedge clk);
      uart_rxd = 1'b1;
      repeat (FRAME + 10) @(negedge clk);
      bus_rd(RDW, STAT_A, d);
      n_chk++; if (d !== stat_val(1, 0, 0, 1)) $display("FAIL rx_glitch got=%h exp=%h", d, stat_val(1, 0, 0, 1)); else n_pass++;
      send_rx(8'($urandom), 1'b0);
      repeat (10) @(negedge clk);
      bus_rd(RDW, STAT_A, d);
      n_chk++; if (d !== stat_val(1, 0, 0, 1)) $display("FAIL rx_bad_stop got=%h exp=%h", d, stat_val(1, 0, 0, 1)); else n_pass++;
   endtask

   task automatic test_err();
      logic [31:0] d, w0, w1;
      n_chk++; if (err !== 1'b0) $display("FAIL err_pre got=%b exp=0", err); else n_pass++;
      bus_rd(RDW, 32'h0000_0000, d);
      n_chk++; if (d !== 32'd0) $display("FAIL err_unmapped_rd got=%h exp=0", d); else n_pass++;
      n_chk++; if (err !== 1'b1) $display("FAIL err_unmapped_set got=%b exp=1", err); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++; if (err !== 1'b0) $display("FAIL err_reset got=%b exp=0", err); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      w0 = mdl_word(0);
      w1 = mdl_word(1);
      bus_wr(WRW, 32'h8000_0001, ~w0);
      n_chk++; if (err !== 1'b1) $display("FAIL err_misalign_set got=%b exp=1", err); else n_pass++;
      bus_rd(RDW, RAM_A, d);
      n_chk++; if (d !== w0) $display("FAIL err_ram0_kept got=%h exp=%h", d, w0); else n_pass++;
      bus_rd(RDW, RAM_A + 32'd4, d);
      n_chk++; if (d !== w1) $display("FAIL err_ram1_kept got=%h exp=%h", d, w1); else n_pass++;
      bus_rd(RDW, RAM_A + 32'(RW * 4), d);
      n_chk++; if (d !== 32'd0) $display("FAIL err_ram_end got=%h exp=0", d); else n_pass++;
      bus_rd(RDW, STAT_A + 32'd1, d);
      n_chk++; if (d !== 32'd0) $display("FAIL err_uart_misalign got=%h exp=0", d); else n_pass++;
      n_chk++; if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err); else n_pass++;
   endtask

   task automatic test_reset_mid_tx();
      logic [31:0] d;
      bus_wr(WRW, DATA_A, 32'h0000_0000);
      bus_wr(WRW, DATA_A, 32'h0000_0011);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_chk++; if (uart_txd !== 1'b1) $display("FAIL rst_mid_txd got=%b exp=1", uart_txd); else n_pass++;
      bus_rd(RDW, STAT_A, d);
      n_chk++; if (d !== stat_val(1, 0, 0, 1)) $display("FAIL rst_mid_status got=%h exp=%h", d, stat_val(1, 0, 0, 1)); else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_rd(RDW, CYC_A, d);
         n_chk++; if (d !== 32'(i)) $display("FAIL rst_cycles i=%0d got=%h exp=%h", i, d, 32'(i)); else n_pass++;
      end
      repeat (FRAME + 20) @(negedge clk);
      n_chk++; if (uart_txd !== 1'b1) $display("FAIL rst_no_resume got=%b exp=1", uart_txd); else n_pass++;
      cap_q.delete(); start_q.delete();
   endtask

   initial begin
      test_reset();
      test_ram();
      test_cycles();
      test_tx_frame();
      test_back_to_back();
      test_tx_random();
      test_rx();
      test_err();
      test_reset_mid_tx();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
